// File: rtl/uart_tx_if.sv
// Transmit-side port bundle for uart_tx: word request in, serial line and status out.
// o_state is a one-hot debug view of the transmitter FSM.
interface uart_tx_if #(
  parameter int WIDTH_WORD = 8
);
  // Handshake: i_tx_start is a request that the transmitter takes on any clock
  // while o_busy is low (o_busy acts as the inverted ready); i_data_in is
  // captured on that same clock. o_busy then stays high up to and including
  // the one-clock o_tx_done pulse. A request seen while o_busy is high is
  // dropped, not queued.
  logic                  i_tx_start;
  logic [WIDTH_WORD-1:0] i_data_in;
  logic                  o_bit_tx;
  logic                  o_tx_done;
  logic                  o_busy;
  logic [4:0]            o_state;

  modport master (
    output i_tx_start, i_data_in,
    input  o_bit_tx, o_tx_done, o_busy, o_state
  );

  modport slave (
    input  i_tx_start, i_data_in,
    output o_bit_tx, o_tx_done, o_busy, o_state
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, MSB first, 16 rate ticks per bit, CANT_BIT_STOP stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int WIDTH_WORD    = 8,
  parameter int CANT_BIT_STOP = 1
) (
  input  logic    i_clock,
  input  logic    i_reset,
  input  logic    i_rate,
  uart_tx_if.slave tx
);
  localparam int CNT_W = $clog2(WIDTH_WORD) + 1;

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_START  = 5'b00010;
  localparam logic [4:0] S_DATA   = 5'b00100;
`ifdef UART_TX_PARITY_EN
  localparam logic [4:0] S_PARITY = 5'b01000;
`endif
  localparam logic [4:0] S_STOP   = 5'b10000;

  logic [4:0]            state, state_next;
  logic [3:0]            tick_cnt, tick_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [WIDTH_WORD-1:0] shift_buf, shift_next;
  logic                  bit_tx_q, bit_tx_next;
  logic                  done_q, done_next;
  logic                  busy_q, busy_next;

  logic bit_end;
  logic last_data;
  logic last_stop;

  assign bit_end   = i_rate && (tick_cnt == 4'd15);
  assign last_data = (bit_cnt == CNT_W'(WIDTH_WORD - 1));
  assign last_stop = (bit_cnt == CNT_W'(CANT_BIT_STOP - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_buf <= '0;
      bit_tx_q  <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_cnt_next;
      shift_buf <= shift_next;
      bit_tx_q  <= bit_tx_next;
      done_q    <= done_next;
      busy_q    <= busy_next;
    end
  end

  // Only start acceptance may move the FSM on a clock without i_rate.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (tx.i_tx_start && !busy_q) state_next = S_START;
      S_START: if (bit_end) state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (bit_end && last_data) state_next = S_PARITY;
      S_PARITY: if (bit_end) state_next = S_STOP;
`else
      S_DATA:   if (bit_end && last_data) state_next = S_STOP;
`endif
      S_STOP:  if (bit_end && last_stop) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Buffer rotates rather than shifts so its XOR still equals the word's parity.
  always_comb begin
    tick_next    = tick_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_buf;
    bit_tx_next  = 1'b1;
    if (state == S_IDLE) begin
      tick_next    = '0;
      bit_cnt_next = '0;
      if (state_next == S_START) shift_next = tx.i_data_in;
    end else if (i_rate) begin
      tick_next = bit_end ? 4'd0 : tick_cnt + 4'd1;
      if (bit_end) bit_cnt_next = (state_next != state) ? '0 : bit_cnt + CNT_W'(1);
      if (bit_end && state == S_DATA)
        shift_next = {shift_buf[WIDTH_WORD-2:0], shift_buf[WIDTH_WORD-1]};
    end

    case (state_next)
      S_START:  bit_tx_next = 1'b0;
      S_DATA:   bit_tx_next = shift_next[WIDTH_WORD-1];
`ifdef UART_TX_PARITY_EN
      S_PARITY: bit_tx_next = ^shift_buf;
`endif
      default:  bit_tx_next = 1'b1;
    endcase

    done_next = (state == S_STOP) && (state_next == S_IDLE);
    busy_next = (state_next != S_IDLE) || done_next;
  end

  assign tx.o_bit_tx  = bit_tx_q;
  assign tx.o_tx_done = done_q;
  assign tx.o_busy    = busy_q;
  assign tx.o_state   = state;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-tick line scoreboard, stop-bit variants, reset abort.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME1 = 16 * (1 + W + PAR + 1);
  localparam int FRAME2 = 16 * (1 + W + PAR + 2);
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_START = 5'b00010;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rate = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.WIDTH_WORD(W)) tx_if ();
  uart_tx_if #(.WIDTH_WORD(W)) tx2_if ();

  uart_tx #(.WIDTH_WORD(W), .CANT_BIT_STOP(1)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .tx(tx_if)
  );
  uart_tx #(.WIDTH_WORD(W), .CANT_BIT_STOP(2)) dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .tx(tx2_if)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int busy_ticks = 0;
  int gap_ticks  = 0;
  int done_cnt   = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp2_q[$];

  // rate pulse every 4th clock, changed just after the rising edge
  initial begin : rate_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      rate = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // scoreboard for dut: one expected line value per rate tick of a frame
  initial begin : monitor
    logic [0:0] e;
    forever begin
      @(negedge clk);
      if (tx_if.o_tx_done) done_cnt++;
      if (rate && (!tx_if.o_busy || tx_if.o_tx_done)) gap_ticks++;
      if (rate && tx_if.o_busy && !tx_if.o_tx_done) begin
        busy_ticks++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL line_extra: tick %0d of frame has no expected bit, got line=%b", busy_ticks, tx_if.o_bit_tx);
        end else begin
          e = exp_q.pop_front();
          if (tx_if.o_bit_tx !== e) begin
            n_fail++;
            $display("FAIL line_bit: tick %0d got=%b exp=%b", busy_ticks, tx_if.o_bit_tx, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish exp finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic push_frame(input logic [W-1:0] d, input int nstop, input bit to_dut2);
    logic [0:0] bits[$];
    bits.push_back(1'b0);
    for (int i = W - 1; i >= 0; i--) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back(^d);
    for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
    foreach (bits[j])
      for (int t = 0; t < 16; t++)
        if (to_dut2) exp2_q.push_back(bits[j]);
        else exp_q.push_back(bits[j]);
  endtask

  task automatic start_frame(input logic [W-1:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (tx_if.o_busy && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) begin
      n_assert++; n_fail++;
      $display("FAIL start_wait: busy got=1 exp=0 within 4000 clocks");
    end
    tx_if.i_data_in  = d;
    tx_if.i_tx_start = 1'b1;
    push_frame(d, 1, 1'b0);
    @(negedge clk);
    tx_if.i_tx_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      n_assert++; n_fail++;
      $display("FAIL done_wait: done_cnt got=%0d exp=%0d", done_cnt, target);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_counts();
    @(posedge clk);
    busy_ticks = 0;
    gap_ticks  = 0;
    done_cnt   = 0;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    tx_if.i_tx_start = 1'b1;
    tx_if.i_data_in  = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++; if (tx_if.o_bit_tx !== 1'b1) begin n_fail++; $display("FAIL rst_line: got=%b exp=1", tx_if.o_bit_tx); end
    n_assert++; if (tx_if.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_prio: got=%b exp=0", tx_if.o_busy); end
    n_assert++; if (tx_if.o_tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got=%b exp=0", tx_if.o_tx_done); end
    n_assert++; if (tx_if.o_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got=%b exp=%b", tx_if.o_state, ST_IDLE); end
    n_assert++; if (tx2_if.o_bit_tx !== 1'b1) begin n_fail++; $display("FAIL rst_line2: got=%b exp=1", tx2_if.o_bit_tx); end
    tx_if.i_tx_start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int guard;
    clear_counts();
    start_frame(8'hA5);
    n_assert++; if (tx_if.o_busy !== 1'b1) begin n_fail++; $display("FAIL accept_busy: got=%b exp=1", tx_if.o_busy); end
    n_assert++; if (tx_if.o_bit_tx !== 1'b0) begin n_fail++; $display("FAIL accept_line: got=%b exp=0", tx_if.o_bit_tx); end
    n_assert++; if (tx_if.o_state !== ST_START) begin n_fail++; $display("FAIL accept_state: got=%b exp=%b", tx_if.o_state, ST_START); end
    guard = 0;
    while (!tx_if.o_tx_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_assert++; if (tx_if.o_busy !== 1'b1) begin n_fail++; $display("FAIL done_busy: busy during done got=%b exp=1", tx_if.o_busy); end
    @(negedge clk);
    n_assert++; if (tx_if.o_tx_done !== 1'b0) begin n_fail++; $display("FAIL done_width: got=%b exp=0", tx_if.o_tx_done); end
    n_assert++; if (tx_if.o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got=%b exp=0", tx_if.o_busy); end
    @(posedge clk);
    n_assert++; if (busy_ticks != FRAME1) begin n_fail++; $display("FAIL basic_ticks: got=%0d exp=%0d", busy_ticks, FRAME1); end
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got=%0d exp=1", done_cnt); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_ignore();
    clear_counts();
    start_frame(8'hA5);
    repeat (200) @(negedge clk);
    tx_if.i_data_in  = 8'h3C;
    tx_if.i_tx_start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      tx_if.i_data_in = W'($urandom_range(0, 255));
    end
    tx_if.i_tx_start = 1'b0;
    wait_done(1);
    repeat (100) @(posedge clk);
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done: got=%0d exp=1", done_cnt); end
    n_assert++; if (busy_ticks != FRAME1) begin n_fail++; $display("FAIL ignore_ticks: got=%0d exp=%0d", busy_ticks, FRAME1); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ignore_drain: left=%0d exp=0", exp_q.size()); end
    n_assert++; if (tx_if.o_busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: busy got=%b exp=0", tx_if.o_busy); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    start_frame(8'h00);
    @(posedge clk);
    gap_ticks = 0;
    start_frame(8'hFF);
    @(posedge clk);
    n_assert++; if (gap_ticks != 0) begin n_fail++; $display("FAIL b2b_gap: idle ticks got=%0d exp=0", gap_ticks); end
    wait_done(2);
    n_assert++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got=%0d exp=2", done_cnt); end
    n_assert++; if (busy_ticks != 2 * FRAME1) begin n_fail++; $display("FAIL b2b_ticks: got=%0d exp=%0d", busy_ticks, 2 * FRAME1); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_counts();
    start_frame(8'h55);
    guard = 0;
    while (busy_ticks < 88 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_assert++; if (tx_if.o_bit_tx !== 1'b1) begin n_fail++; $display("FAIL abort_line: got=%b exp=1", tx_if.o_bit_tx); end
    n_assert++; if (tx_if.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got=%b exp=0", tx_if.o_busy); end
    n_assert++; if (tx_if.o_tx_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got=%b exp=0", tx_if.o_tx_done); end
    n_assert++; if (tx_if.o_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got=%b exp=%b", tx_if.o_state, ST_IDLE); end
    exp_q.delete();
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    n_assert++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_nodone: got=%0d exp=0", done_cnt); end
    n_assert++; if (tx_if.o_bit_tx !== 1'b1) begin n_fail++; $display("FAIL abort_idle_line: got=%b exp=1", tx_if.o_bit_tx); end
  endtask

  task automatic test_random();
    clear_counts();
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      start_frame(W'($urandom_range(0, 255)));
    end
    wait_done(3);
    n_assert++; if (done_cnt != 3) begin n_fail++; $display("FAIL rand_done: got=%0d exp=3", done_cnt); end
    n_assert++; if (busy_ticks != 3 * FRAME1) begin n_fail++; $display("FAIL rand_ticks: got=%0d exp=%0d", busy_ticks, 3 * FRAME1); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: left=%0d exp=0", exp_q.size()); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    clear_counts();
    start_frame(8'h01);
    wait_done(1);
    start_frame(8'hA5);
    wait_done(2);
    n_assert++; if (busy_ticks != 2 * FRAME1) begin n_fail++; $display("FAIL par_ticks: got=%0d exp=%0d", busy_ticks, 2 * FRAME1); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL par_drain: left=%0d exp=0", exp_q.size()); end
  endtask
`endif

  task automatic test_two_stop();
    int guard;
    int t2;
    int d2;
    logic [0:0] e;
    t2 = 0;
    d2 = 0;
    guard = 0;
    @(negedge clk);
    tx2_if.i_data_in  = 8'h81;
    tx2_if.i_tx_start = 1'b1;
    push_frame(8'h81, 2, 1'b1);
    @(negedge clk);
    tx2_if.i_tx_start = 1'b0;
    while (d2 == 0 && guard < 3000) begin
      if (tx2_if.o_tx_done) d2++;
      else if (rate && tx2_if.o_busy) begin
        t2++;
        e = (exp2_q.size() != 0) ? exp2_q.pop_front() : 1'bx;
        n_assert++;
        if (tx2_if.o_bit_tx !== e) begin n_fail++; $display("FAIL stop2_bit: tick %0d got=%b exp=%b", t2, tx2_if.o_bit_tx, e); end
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin n_assert++; n_fail++; $display("FAIL stop2_wait: no done got=0 exp=1"); end
    n_assert++; if (t2 != FRAME2) begin n_fail++; $display("FAIL stop2_ticks: got=%0d exp=%0d", t2, FRAME2); end
    n_assert++; if (exp2_q.size() != 0) begin n_fail++; $display("FAIL stop2_drain: left=%0d exp=0", exp2_q.size()); end
    n_assert++; if (tx2_if.o_tx_done !== 1'b0) begin n_fail++; $display("FAIL stop2_done_width: got=%b exp=0", tx2_if.o_tx_done); end
  endtask

  initial begin : main
    tx_if.i_tx_start  = 1'b0;
    tx_if.i_data_in   = '0;
    tx2_if.i_tx_start = 1'b0;
    tx2_if.i_data_in  = '0;
    test_reset();
    test_basic();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_two_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter WIDTH_WORD, default 8: data bits per frame.
REQ-002 SHALL have parameter CANT_BIT_STOP, default 1: stop bits per frame (1 or 2).
REQ-003 SHALL have port i_clock, input, 1: system clock, all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_rate, input, 1: baud tick enable, one-cycle pulse at 16x bit rate.
REQ-006 SHALL have port i_tx_start, input, 1: request to send i_data_in.
REQ-007 SHALL have port i_data_in, input, WIDTH_WORD: word to transmit.
REQ-008 SHALL have port o_bit_tx, output, 1: serial line, registered, idle high.
REQ-009 SHALL have port o_tx_done, output, 1: one-clock pulse at end of frame.
REQ-010 SHALL have port o_busy, output, 1: high from start acceptance until o_tx_done pulse inclusive.

Function
REQ-011 SHALL implement one-hot states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 SHALL, in IDLE with i_tx_start high on any clock (i_rate not required), latch i_data_in into a shift buffer, enter START, and assert o_busy on the next clock.
REQ-013 SHALL ignore i_tx_start and changes on i_data_in while o_busy is high; no queuing.
REQ-014 SHALL drive o_bit_tx low in START, data bits in DATA, and high in STOP and IDLE.
REQ-015 SHALL hold every bit for exactly 16 i_rate pulses; the tick counter advances only on clocks with i_rate high and resets to 0 on each bit boundary.
REQ-016 SHALL transmit data MSB first (bit WIDTH_WORD-1 first, bit 0 last).
REQ-017 SHALL count data bits with a counter of $clog2(WIDTH_WORD)+1 bits; leave DATA after the 16th tick of bit WIDTH_WORD.
REQ-018 SHALL send CANT_BIT_STOP stop bits, then return to IDLE on the clock after the 16th tick of the last stop bit.
REQ-019 SHALL pulse o_tx_done high for exactly one clock on the IDLE-return transition; o_busy falls on the following clock.
REQ-020 SHALL accept a new i_tx_start on the first clock after o_busy falls; back-to-back frames have no extra idle ticks beyond the stop bits.
REQ-021 SHALL keep o_bit_tx glitch-free: changes only at bit boundaries or reset.
REQ-022 SHALL hold all state, counters and outputs unchanged on clocks with i_rate low, except start acceptance in IDLE.

Reset
REQ-023 SHALL, when i_reset is low at a rising edge, force IDLE, o_bit_tx=1, o_tx_done=0, o_busy=0, counters and buffer to 0, regardless of i_rate.
REQ-024 SHALL abort a frame in progress on reset mid-operation; line returns high on the next clock with no done pulse.
REQ-025 SHALL give reset priority over i_tx_start on the same clock.

Configuration
REQ-026 SHALL, with macro UART_TX_PARITY_EN defined, insert one PARITY state between DATA and STOP sending even parity (XOR of all data bits) for 16 ticks.
REQ-027 SHALL, without UART_TX_PARITY_EN, go directly DATA to STOP; frame length 16*(1+WIDTH_WORD+CANT_BIT_STOP) ticks.

Verification
REQ-028 SHALL verify: reset, then start with 8'hA5, i_rate every 4 clocks -> line 0,1,0,1,0,0,1,0,1,1 each 16 ticks; o_tx_done once after 160 ticks.
REQ-029 SHALL verify: start 8'h3C asserted mid-frame of 8'hA5 -> ignored; only A5 frame sent, single done pulse.
REQ-030 SHALL verify: back-to-back 8'h00 then 8'hFF, start asserted on clock after o_busy falls -> START bit of second frame follows stop bit directly.
REQ-031 SHALL verify: i_reset low during data bit 3 of 8'h55 -> o_bit_tx=1 next clock, o_busy=0, no o_tx_done.
REQ-032 SHALL verify: UART_TX_PARITY_EN defined, 8'h01 -> parity bit 1; 8'hA5 -> parity bit 0; frame 176 ticks.
REQ-033 SHALL verify: CANT_BIT_STOP=2, 8'h81 -> line high for 32 ticks after bit 0; done after 176 ticks.
